// File: rtl/add_sub_rs_pkg.sv
// Shared types for the add/sub reservation station: decoded controls, entry state and payload.
package add_sub_rs_pkg;

    localparam int unsigned ADD_SUB_LATENCY  = 4;
    // Entry tags are stored at this width; RS_ID_WIDTH must not exceed it.
    localparam int unsigned RS_TAG_MAX_WIDTH = 8;

    typedef struct packed {
        logic subtract;
        logic add_CA;
        logic alter_CA;
        logic alter_OV;
    } add_sub_decode_t;

    typedef enum logic [1:0] {
        RsFree   = 2'd0,
        RsWait   = 2'd1,
        RsIssued = 2'd2
    } rs_entry_state_t;

    typedef struct packed {
        add_sub_decode_t             control;
        logic [4:0]                  result_reg_addr;
        logic [31:0]                 op1;
        logic [31:0]                 op2;
        logic                        ca;
        logic                        op1_valid;
        logic                        op2_valid;
        logic                        ca_valid;
        logic [RS_TAG_MAX_WIDTH-1:0] op1_tag;
        logic [RS_TAG_MAX_WIDTH-1:0] op2_tag;
        logic [RS_TAG_MAX_WIDTH-1:0] ca_tag;
    } add_sub_rs_entry_t;

endpackage

// File: rtl/rs_select_rr.sv
// Combinational round-robin arbiter: highest priority goes to the index just after last_i.
module rs_select_rr #(
    parameter int unsigned RS_ENTRIES = 4,
    parameter int unsigned IDX_W      = 2
) (
    input  logic [RS_ENTRIES-1:0] req_i,
    input  logic [IDX_W-1:0]      last_i,
    output logic [RS_ENTRIES-1:0] gnt_o,
    output logic [IDX_W-1:0]      gnt_idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= RS_ENTRIES; k++) begin
            cand = IDX_W'((32'(last_i) + k) % RS_ENTRIES);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/add_sub_rs.sv
// Reservation station for the add/sub unit: buffers dispatched ops, snoops the CDB,
// issues one ready entry per cycle and keeps its tag reserved until the unit completes it.
module add_sub_rs
    import add_sub_rs_pkg::*;
#(
    parameter int unsigned RS_ENTRIES  = 4,
    parameter int unsigned RS_ID_WIDTH = 5,
    parameter int unsigned RS_OFFSET   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   dispatch_valid_i,
    output logic                   dispatch_ready_o,
    output logic [RS_ID_WIDTH-1:0] dispatch_rs_id_o,
    input  add_sub_decode_t        dispatch_control_i,
    input  logic [4:0]             dispatch_result_reg_addr_i,
    input  logic [31:0]            dispatch_op1_i,
    input  logic [31:0]            dispatch_op2_i,
    input  logic                   dispatch_op1_valid_i,
    input  logic                   dispatch_op2_valid_i,
    input  logic [RS_ID_WIDTH-1:0] dispatch_op1_tag_i,
    input  logic [RS_ID_WIDTH-1:0] dispatch_op2_tag_i,
    input  logic                   dispatch_ca_i,
    input  logic                   dispatch_ca_valid_i,
    input  logic [RS_ID_WIDTH-1:0] dispatch_ca_tag_i,
    input  logic                   cdb_valid_i,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id_i,
    input  logic [31:0]            cdb_result_i,
    input  logic                   cdb_ca_i,
    output logic                   issue_valid_o,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id_o,
    output logic [4:0]             issue_result_reg_addr_o,
    output logic [31:0]            issue_op1_o,
    output logic [31:0]            issue_op2_o,
    output logic                   issue_carry_o,
    output add_sub_decode_t        issue_control_o,
    input  logic                   unit_output_valid_i,
    input  logic [RS_ID_WIDTH-1:0] unit_rs_id_i
);

    localparam int unsigned IDX_W   = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;
    localparam int unsigned DRAIN_W = $clog2(ADD_SUB_LATENCY + 1);

    rs_entry_state_t   state_q [RS_ENTRIES];
    rs_entry_state_t   state_d [RS_ENTRIES];
    add_sub_rs_entry_t entry_q [RS_ENTRIES];
    add_sub_rs_entry_t entry_d [RS_ENTRIES];
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    logic                   issue_valid_q, issue_valid_d;
    logic [RS_ID_WIDTH-1:0] issue_rs_id_q, issue_rs_id_d;
    logic [4:0]             issue_addr_q, issue_addr_d;
    logic [31:0]            issue_op1_q, issue_op1_d;
    logic [31:0]            issue_op2_q, issue_op2_d;
    logic                   issue_carry_q, issue_carry_d;
    add_sub_decode_t        issue_control_q, issue_control_d;

    logic [RS_ENTRIES-1:0]       free_vec, ready_vec, gnt;
    logic [IDX_W-1:0]            alloc_idx, gnt_idx;
    logic                        any_free;
    logic [RS_TAG_MAX_WIDTH-1:0] cdb_tag_w;
    add_sub_rs_entry_t           new_entry;

    function automatic logic [RS_ID_WIDTH-1:0] tag_of(logic [IDX_W-1:0] idx);
        return RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(idx);
    endfunction

    assign cdb_tag_w = RS_TAG_MAX_WIDTH'(cdb_rs_id_i);

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < int'(RS_ENTRIES); i++) begin
            free_vec[i]  = (state_q[i] == RsFree);
            ready_vec[i] = (state_q[i] == RsWait) && entry_q[i].op1_valid &&
                           entry_q[i].op2_valid && entry_q[i].ca_valid;
        end
    end

    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        for (int i = int'(RS_ENTRIES) - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                any_free  = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign dispatch_ready_o = any_free && (drain_q == '0);
    assign dispatch_rs_id_o = tag_of(alloc_idx);

    rs_select_rr #(
        .RS_ENTRIES (RS_ENTRIES),
        .IDX_W      (IDX_W)
    ) u_select (
        .req_i     (ready_vec),
        .last_i    (rr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // Incoming operands also snoop the CDB so a same-cycle broadcast is not missed.
    always_comb begin
        new_entry                 = '0;
        new_entry.control         = dispatch_control_i;
        new_entry.result_reg_addr = dispatch_result_reg_addr_i;
        new_entry.op1_tag         = RS_TAG_MAX_WIDTH'(dispatch_op1_tag_i);
        new_entry.op2_tag         = RS_TAG_MAX_WIDTH'(dispatch_op2_tag_i);
        new_entry.ca_tag          = RS_TAG_MAX_WIDTH'(dispatch_ca_tag_i);
        new_entry.op1_valid = dispatch_op1_valid_i ||
                              (cdb_valid_i && (dispatch_op1_tag_i == cdb_rs_id_i));
        new_entry.op1       = dispatch_op1_valid_i ? dispatch_op1_i : cdb_result_i;
        new_entry.op2_valid = dispatch_op2_valid_i ||
                              (cdb_valid_i && (dispatch_op2_tag_i == cdb_rs_id_i));
        new_entry.op2       = dispatch_op2_valid_i ? dispatch_op2_i : cdb_result_i;
        if (!dispatch_control_i.add_CA) begin
            new_entry.ca_valid = 1'b1;
            new_entry.ca       = 1'b0;
        end else begin
            new_entry.ca_valid = dispatch_ca_valid_i ||
                                 (cdb_valid_i && (dispatch_ca_tag_i == cdb_rs_id_i));
            new_entry.ca       = dispatch_ca_valid_i ? dispatch_ca_i : cdb_ca_i;
        end
    end

    always_comb begin
        state_d         = state_q;
        entry_d         = entry_q;
        rr_d            = rr_q;
        drain_d         = drain_q;
        issue_valid_d   = 1'b0;
        issue_rs_id_d   = issue_rs_id_q;
        issue_addr_d    = issue_addr_q;
        issue_op1_d     = issue_op1_q;
        issue_op2_d     = issue_op2_q;
        issue_carry_d   = issue_carry_q;
        issue_control_d = issue_control_q;

        if (drain_q != '0) drain_d = drain_q - DRAIN_W'(1);

        for (int i = 0; i < int'(RS_ENTRIES); i++) begin
            if (state_q[i] == RsWait && cdb_valid_i) begin
                if (!entry_q[i].op1_valid && entry_q[i].op1_tag == cdb_tag_w) begin
                    entry_d[i].op1       = cdb_result_i;
                    entry_d[i].op1_valid = 1'b1;
                end
                if (!entry_q[i].op2_valid && entry_q[i].op2_tag == cdb_tag_w) begin
                    entry_d[i].op2       = cdb_result_i;
                    entry_d[i].op2_valid = 1'b1;
                end
                if (!entry_q[i].ca_valid && entry_q[i].ca_tag == cdb_tag_w) begin
                    entry_d[i].ca       = cdb_ca_i;
                    entry_d[i].ca_valid = 1'b1;
                end
            end
            if (state_q[i] == RsIssued && unit_output_valid_i &&
                unit_rs_id_i == tag_of(IDX_W'(i))) begin
                state_d[i] = RsFree;
            end
        end

        if (dispatch_valid_i && dispatch_ready_o) begin
            state_d[alloc_idx] = RsWait;
            entry_d[alloc_idx] = new_entry;
        end

        if (|gnt) begin
            state_d[gnt_idx] = RsIssued;
            rr_d             = gnt_idx;
            issue_valid_d    = 1'b1;
            issue_rs_id_d    = tag_of(gnt_idx);
            issue_addr_d     = entry_q[gnt_idx].result_reg_addr;
            issue_op1_d      = entry_q[gnt_idx].op1;
            issue_op2_d      = entry_q[gnt_idx].op2;
            issue_carry_d    = entry_q[gnt_idx].ca;
            issue_control_d  = entry_q[gnt_idx].control;
        end

        // Draining keeps old tags unallocated until in-flight results have left the unit.
        if (flush_i) begin
            for (int i = 0; i < int'(RS_ENTRIES); i++) state_d[i] = RsFree;
            issue_valid_d = 1'b0;
            drain_d       = DRAIN_W'(ADD_SUB_LATENCY);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(RS_ENTRIES); i++) begin
                state_q[i] <= RsFree;
                entry_q[i] <= '0;
            end
            rr_q            <= '0;
            drain_q         <= '0;
            issue_valid_q   <= 1'b0;
            issue_rs_id_q   <= '0;
            issue_addr_q    <= '0;
            issue_op1_q     <= '0;
            issue_op2_q     <= '0;
            issue_carry_q   <= 1'b0;
            issue_control_q <= '0;
        end else begin
            state_q         <= state_d;
            entry_q         <= entry_d;
            rr_q            <= rr_d;
            drain_q         <= drain_d;
            issue_valid_q   <= issue_valid_d;
            issue_rs_id_q   <= issue_rs_id_d;
            issue_addr_q    <= issue_addr_d;
            issue_op1_q     <= issue_op1_d;
            issue_op2_q     <= issue_op2_d;
            issue_carry_q   <= issue_carry_d;
            issue_control_q <= issue_control_d;
        end
    end

    assign issue_valid_o           = issue_valid_q;
    assign issue_rs_id_o           = issue_rs_id_q;
    assign issue_result_reg_addr_o = issue_addr_q;
    assign issue_op1_o             = issue_op1_q;
    assign issue_op2_o             = issue_op2_q;
    assign issue_carry_o           = issue_carry_q;
    assign issue_control_o         = issue_control_q;

endmodule

// File: tb/tb_add_sub_rs.sv
// Directed bench for add_sub_rs with an issue scoreboard checked at every falling edge.
`timescale 1ns/1ps
module tb_add_sub_rs;
    import add_sub_rs_pkg::*;

    localparam int unsigned ENTRIES = 4;
    localparam int unsigned IDW     = 5;
    localparam int unsigned OFF     = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            d_valid, d_ready;
    logic [IDW-1:0]  d_rs_id;
    add_sub_decode_t d_ctl;
    logic [4:0]      d_addr;
    logic [31:0]     d_op1, d_op2;
    logic            d_v1, d_v2;
    logic [IDW-1:0]  d_t1, d_t2;
    logic            d_ca, d_cav;
    logic [IDW-1:0]  d_cat;
    logic            cdb_valid;
    logic [IDW-1:0]  cdb_id;
    logic [31:0]     cdb_res;
    logic            cdb_ca;
    logic            i_valid;
    logic [IDW-1:0]  i_rs_id;
    logic [4:0]      i_addr;
    logic [31:0]     i_op1, i_op2;
    logic            i_carry;
    add_sub_decode_t i_ctl;
    logic            u_valid;
    logic [IDW-1:0]  u_id;

    typedef struct {
        logic [IDW-1:0] rs_id;
        logic [4:0]     addr;
        logic [31:0]    op1;
        logic [31:0]    op2;
        logic           carry;
        logic [3:0]     ctl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    add_sub_rs #(
        .RS_ENTRIES  (ENTRIES),
        .RS_ID_WIDTH (IDW),
        .RS_OFFSET   (OFF)
    ) dut (
        .clk_i                      (clk),
        .rst_ni                     (rst_n),
        .flush_i                    (flush),
        .dispatch_valid_i           (d_valid),
        .dispatch_ready_o           (d_ready),
        .dispatch_rs_id_o           (d_rs_id),
        .dispatch_control_i         (d_ctl),
        .dispatch_result_reg_addr_i (d_addr),
        .dispatch_op1_i             (d_op1),
        .dispatch_op2_i             (d_op2),
        .dispatch_op1_valid_i       (d_v1),
        .dispatch_op2_valid_i       (d_v2),
        .dispatch_op1_tag_i         (d_t1),
        .dispatch_op2_tag_i         (d_t2),
        .dispatch_ca_i              (d_ca),
        .dispatch_ca_valid_i        (d_cav),
        .dispatch_ca_tag_i          (d_cat),
        .cdb_valid_i                (cdb_valid),
        .cdb_rs_id_i                (cdb_id),
        .cdb_result_i               (cdb_res),
        .cdb_ca_i                   (cdb_ca),
        .issue_valid_o              (i_valid),
        .issue_rs_id_o              (i_rs_id),
        .issue_result_reg_addr_o    (i_addr),
        .issue_op1_o                (i_op1),
        .issue_op2_o                (i_op2),
        .issue_carry_o              (i_carry),
        .issue_control_o            (i_ctl),
        .unit_output_valid_i        (u_valid),
        .unit_rs_id_i               (u_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && i_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue", {31'd0, i_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("issue_rs_id", 32'(i_rs_id), 32'(e.rs_id));
                chk("issue_addr", 32'(i_addr), 32'(e.addr));
                chk("issue_op1", i_op1, e.op1);
                chk("issue_op2", i_op2, e.op2);
                chk("issue_carry", {31'd0, i_carry}, {31'd0, e.carry});
                chk("issue_control", {28'd0, i_ctl}, {28'd0, e.ctl});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [31:0] op1, input logic v1, input logic [IDW-1:0] t1,
                        input logic [31:0] op2, input logic add_ca, input logic cav,
                        input logic [IDW-1:0] cat, input logic [4:0] addr);
        d_valid      = 1'b1;
        d_ctl        = '0;
        d_ctl.add_CA = add_ca;
        d_op1        = op1;
        d_v1         = v1;
        d_t1         = t1;
        d_op2        = op2;
        d_v2         = 1'b1;
        d_t2         = '0;
        d_ca         = 1'b0;
        d_cav        = cav;
        d_cat        = cat;
        d_addr       = addr;
    endtask

    task automatic push(input int unsigned id, input logic [31:0] op1, input logic [31:0] op2,
                        input logic carry, input logic [4:0] addr, input logic [3:0] ctl);
        exp_t e;
        e.rs_id = IDW'(id);
        e.op1   = op1;
        e.op2   = op2;
        e.carry = carry;
        e.addr  = addr;
        e.ctl   = ctl;
        sb.push_back(e);
    endtask

    task automatic cdb(input logic [IDW-1:0] id, input logic [31:0] res, input logic ca);
        cdb_valid = 1'b1;
        cdb_id    = id;
        cdb_res   = res;
        cdb_ca    = ca;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; d_valid = 1'b0; d_ctl = '0; d_addr = '0;
        d_op1 = '0; d_op2 = '0; d_v1 = 1'b0; d_v2 = 1'b0; d_t1 = '0; d_t2 = '0;
        d_ca = 1'b0; d_cav = 1'b0; d_cat = '0; cdb_valid = 1'b0; cdb_id = '0;
        cdb_res = '0; cdb_ca = 1'b0; u_valid = 1'b0; u_id = '0;
        #3;
        chk("rst_issue_valid", {31'd0, i_valid}, 32'd0);
        chk("rst_dispatch_ready", {31'd0, d_ready}, 32'd1);
        chk("rst_dispatch_rs_id", 32'(d_rs_id), OFF);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back: all operands valid, issues one cycle after acceptance.
        chk("b2b_alloc_id", 32'(d_rs_id), OFF);
        disp(32'd5, 1'b1, 5'd0, 32'd7, 1'b0, 1'b0, 5'd0, 5'd3);
        push(OFF, 32'd5, 32'd7, 1'b0, 5'd3, 4'b0000);
        tick();
        d_valid = 1'b0;
        chk("b2b_no_issue_yet", {31'd0, i_valid}, 32'd0);
        tick();
        chk("b2b_issue", {31'd0, i_valid}, 32'd1);
        u_valid = 1'b1; u_id = IDW'(OFF);
        tick();
        u_valid = 1'b0;
        chk("b2b_single_pulse", {31'd0, i_valid}, 32'd0);
        chk("b2b_freed", 32'(d_rs_id), OFF);

        // Same-cycle wakeup via dispatch bypass.
        disp(32'd0, 1'b0, 5'd9, 32'd2, 1'b0, 1'b0, 5'd0, 5'd4);
        cdb(5'd9, 32'h10, 1'b0);
        push(OFF, 32'h10, 32'd2, 1'b0, 5'd4, 4'b0000);
        tick();
        d_valid = 1'b0; cdb_valid = 1'b0;
        tick();
        chk("bypass_issue", {31'd0, i_valid}, 32'd1);
        u_valid = 1'b1; u_id = IDW'(OFF);
        tick();
        u_valid = 1'b0;

        // CA dependency: no issue until tag 3 broadcasts its carry.
        disp(32'd1, 1'b1, 5'd0, 32'd2, 1'b1, 1'b0, 5'd3, 5'd5);
        tick();
        d_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("ca_wait", {31'd0, i_valid}, 32'd0);
            tick();
        end
        cdb(5'd3, 32'hdead, 1'b1);
        push(OFF, 32'd1, 32'd2, 1'b1, 5'd5, 4'b0100);
        tick();
        cdb_valid = 1'b0;
        chk("ca_wake_latency", {31'd0, i_valid}, 32'd0);
        tick();
        chk("ca_issue", {31'd0, i_valid}, 32'd1);
        u_valid = 1'b1; u_id = 5'd3;
        tick();
        chk("oor_low_ignored", 32'(d_rs_id), OFF + 1);
        u_id = 5'd8;
        tick();
        chk("oor_high_ignored", 32'(d_rs_id), OFF + 1);
        u_id = IDW'(OFF);
        tick();
        u_valid = 1'b0;
        chk("ca_freed", 32'(d_rs_id), OFF);

        // Fill all entries waiting on tag 20, then wake them together.
        for (int i = 0; i < int'(ENTRIES); i++) begin
            chk("fill_ready", {31'd0, d_ready}, 32'd1);
            chk("fill_alloc_id", 32'(d_rs_id), OFF + i);
            disp(32'd0, 1'b0, 5'd20, 32'(i), 1'b0, 1'b0, 5'd0, 5'(i));
            tick();
        end
        d_valid = 1'b0;
        chk("full_not_ready", {31'd0, d_ready}, 32'd0);
        disp(32'h55, 1'b1, 5'd0, 32'h66, 1'b0, 1'b0, 5'd0, 5'd31);
        tick();
        d_valid = 1'b0;
        chk("full_no_issue", {31'd0, i_valid}, 32'd0);
        // Last issue was entry 0, so the round-robin order is 1, 2, 3, 0.
        for (int k = 1; k <= int'(ENTRIES); k++) begin
            int unsigned idx;
            idx = k % ENTRIES;
            push(OFF + idx, 32'h100, 32'(idx), 1'b0, 5'(idx), 4'b0000);
        end
        cdb(5'd20, 32'h100, 1'b0);
        tick();
        cdb_valid = 1'b0;
        for (int k = 0; k < int'(ENTRIES); k++) begin
            tick();
            chk("rr_issue", {31'd0, i_valid}, 32'd1);
        end
        u_valid = 1'b1; u_id = IDW'(OFF + 2);
        chk("complete_not_same_cycle", {31'd0, d_ready}, 32'd0);
        tick();
        chk("complete_ready", {31'd0, d_ready}, 32'd1);
        chk("complete_alloc_id", 32'(d_rs_id), OFF + 2);
        u_id = IDW'(OFF + 3);
        tick();
        u_valid = 1'b0;
        chk("lowest_free_kept", 32'(d_rs_id), OFF + 2);

        // Flush with two entries in flight and one about to issue.
        disp(32'h77, 1'b1, 5'd0, 32'd1, 1'b0, 1'b0, 5'd0, 5'd7);
        tick();
        d_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_issue_valid", {31'd0, i_valid}, 32'd0);
        disp(32'h99, 1'b1, 5'd0, 32'd2, 1'b0, 1'b0, 5'd0, 5'd8);
        u_valid = 1'b1; u_id = IDW'(OFF);
        for (int k = 0; k < 4; k++) begin
            chk("drain_not_ready", {31'd0, d_ready}, 32'd0);
            if (k == 1) u_id = IDW'(OFF + 1);
            tick();
        end
        d_valid = 1'b0; u_valid = 1'b0;
        chk("drain_done_ready", {31'd0, d_ready}, 32'd1);
        chk("drain_done_id", 32'(d_rs_id), OFF);

        // Asynchronous reset with live entries and nonzero issue registers.
        disp(32'hab, 1'b1, 5'd0, 32'hcd, 1'b0, 1'b0, 5'd0, 5'd9);
        push(OFF, 32'hab, 32'hcd, 1'b0, 5'd9, 4'b0000);
        tick();
        d_valid = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            disp(32'd0, 1'b0, 5'd30, 32'd3, 1'b0, 1'b0, 5'd0, 5'd10);
            tick();
        end
        d_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_issue_valid", {31'd0, i_valid}, 32'd0);
        chk("arst_issue_rs_id", 32'(i_rs_id), 32'd0);
        chk("arst_issue_addr", 32'(i_addr), 32'd0);
        chk("arst_issue_op1", i_op1, 32'd0);
        chk("arst_issue_op2", i_op2, 32'd0);
        chk("arst_issue_ctl", {28'd0, i_ctl}, 32'd0);
        chk("arst_dispatch_ready", {31'd0, d_ready}, 32'd1);
        chk("arst_dispatch_id", 32'(d_rs_id), OFF);
        @(negedge clk);
        rst_n = 1'b1;
        cdb(5'd30, 32'h1234, 1'b0);
        tick();
        cdb_valid = 1'b0;
        tick();
        tick();
        chk("post_rst_ready", {31'd0, d_ready}, 32'd1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
